// File: rtl/cic_interp_tx.sv
// 3-stage CIC interpolator by 2^LOG2R with a one-entry input buffer.
// Combs run at the input rate and integrators at the tick rate; output is scaled to unity DC gain.
module cic_interp_tx #(
  parameter int DW      = 29,
  parameter int LOG2R   = 3,
  parameter int OUT_DIV = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic signed [DW-1:0] din,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic signed [DW-1:0] dout,
  output logic                 out_valid,
  output logic                 underflow
);

  localparam int IW = DW + 3 * LOG2R;
  localparam int S  = 2 * LOG2R;
  localparam int CW = (OUT_DIV > 1) ? $clog2(OUT_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(OUT_DIV - 1);

  logic [CW-1:0]        cnt_q, cnt_d;
  logic [LOG2R-1:0]     k_q, k_d;
  logic signed [DW-1:0] buf_q, buf_d;
  logic                 buf_full_q, buf_full_d;
  logic signed [IW-1:0] xd_q, xd_d, c1d_q, c1d_d, c2d_q, c2d_d;
  logic signed [IW-1:0] i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
  logic signed [DW-1:0] dout_q, dout_d;
  logic                 out_valid_q;

  logic                 tick, consume, xfer;
  logic signed [IW-1:0] x, c1, c2, c3, u, sh;
  logic signed [DW-1:0] sat;

  always_comb begin
    tick  = 1'b0;
    cnt_d = cnt_q;
    if (en) begin
      if (cnt_q == CNT_LAST) begin
        tick  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign consume   = tick && (k_q == '0);
  assign in_ready  = !buf_full_q;
  assign xfer      = in_valid && !buf_full_q;
  assign underflow = consume && !buf_full_q && !rst;

  // A consumption tick and a transfer never both touch a full buffer, so xfer may simply win.
  always_comb begin
    k_d        = tick ? k_q + LOG2R'(1) : k_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    if (consume) buf_full_d = 1'b0;
    if (xfer) begin
      buf_d      = din;
      buf_full_d = 1'b1;
    end
  end

  always_comb begin
    x = '0;
    if (consume && buf_full_q) x = {{(IW-DW){buf_q[DW-1]}}, buf_q};
    c1    = x - xd_q;
    c2    = c1 - c1d_q;
    c3    = c2 - c2d_q;
    u     = consume ? c3 : '0;
    xd_d  = consume ? x  : xd_q;
    c1d_d = consume ? c1 : c1d_q;
    c2d_d = consume ? c2 : c2d_q;
  end

  always_comb begin
    sh = i3_q >>> S;
    if ((sh[IW-1:DW-1] == '0) || (sh[IW-1:DW-1] == '1)) sat = sh[DW-1:0];
    else if (sh[IW-1])                                     sat = {1'b1, {(DW-1){1'b0}}};
    else                                                   sat = {1'b0, {(DW-1){1'b1}}};
  end

  // Integrators chain on pre-tick values; modular wrap cancels out across the cascade.
  always_comb begin
    i1_d   = i1_q;
    i2_d   = i2_q;
    i3_d   = i3_q;
    dout_d = dout_q;
    if (tick) begin
      i1_d   = i1_q + u;
      i2_d   = i2_q + i1_q;
      i3_d   = i3_q + i2_q;
      dout_d = sat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      k_q         <= '0;
      buf_q       <= '0;
      buf_full_q  <= 1'b0;
      xd_q        <= '0;
      c1d_q       <= '0;
      c2d_q       <= '0;
      i1_q        <= '0;
      i2_q        <= '0;
      i3_q        <= '0;
      dout_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      k_q         <= k_d;
      buf_q       <= buf_d;
      buf_full_q  <= buf_full_d;
      xd_q        <= xd_d;
      c1d_q       <= c1d_d;
      c2d_q       <= c2d_d;
      i1_q        <= i1_d;
      i2_q        <= i2_d;
      i3_q        <= i3_d;
      dout_q      <= dout_d;
      out_valid_q <= tick;
    end
  end

  assign dout      = dout_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_cic_interp_tx.sv
// Directed bench for cic_interp_tx (R=8, OUT_DIV=4): expected outputs come from
// convolving consumed samples with the known 22-tap boxcar^3 impulse response.
module tb_cic_interp_tx;

  localparam int DW      = 29;
  localparam int LOG2R   = 3;
  localparam int OUT_DIV = 4;
  localparam longint MAXV = 268435455;
  localparam longint MINV = -268435456;
  localparam longint G [22] = '{1, 3, 6, 10, 15, 21, 28, 36, 42, 46, 48,
                                48, 46, 42, 36, 28, 21, 15, 10, 6, 3, 1};

  logic                 clk = 1'b0;
  logic                 rst, en, in_valid;
  logic signed [DW-1:0] din;
  logic                 in_ready, out_valid, underflow;
  logic signed [DW-1:0] dout;

  int     checks = 0;
  int     errors = 0;
  int     p, bph, ntick, idx;
  longint xm [32];
  longint xs [32];

  cic_interp_tx #(.DW(DW), .LOG2R(LOG2R), .OUT_DIV(OUT_DIV)) dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .in_valid(in_valid),
    .in_ready(in_ready), .dout(dout), .out_valid(out_valid), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at p=%0d tick=%0d: observed %0d expected %0d", tag, p, ntick, obs, exp);
    end
  endtask

  function automatic longint model(input int t);
    longint acc;
    acc = 0;
    for (int m = 0; m < 32; m++) begin
      int j;
      j = t - 3 - 8 * m;
      if (j >= 0 && j < 22) acc += xm[m] * G[j];
    end
    acc = acc >>> 6;
    if (acc > MAXV) acc = MAXV;
    if (acc < MINV) acc = MINV;
    return acc;
  endfunction

  // One clock: drive, cross the posedge, sample at the negedge, check tick outputs.
  task automatic clk1(input logic v, input logic signed [DW-1:0] d);
    logic tk;
    in_valid = v;
    din      = d;
    tk = en && (bph == OUT_DIV - 1);
    @(posedge clk);
    @(negedge clk);
    p++;
    if (en) bph = (bph + 1) % OUT_DIV;
    chk("out_valid", out_valid, tk);
    if (tk) ntick++;
    chk("dout", dout, (ntick == 0) ? 64'sd0 : model(ntick - 1));
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    din      = '0;
    en       = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_dout", dout, 0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_underflow", underflow, 1'b0);
    @(negedge clk);
    #2 rst = 1'b0;
    p = 0; bph = 0; ntick = 0; idx = 0;
    for (int m = 0; m < 32; m++) begin
      xm[m] = 0;
      xs[m] = 0;
    end
  endtask

  task automatic stream(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      logic go;
      go = in_ready;
      clk1(1'b1, DW'(xs[idx]));
      if (go) idx++;
      chk("in_ready", in_ready, (p % 32) == 4);
      chk("underflow", underflow, 1'b0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; en = 1'b1; in_valid = 1'b0; din = '0;
    p = 0; bph = 0; ntick = 0; idx = 0;
    @(negedge clk);

    // Idle: zeros out, out_valid every 4 clks, underflow every 32 clks.
    do_reset();
    for (int c = 0; c < 64; c++) begin
      clk1(1'b0, '0);
      chk("idle_in_ready", in_ready, 1'b1);
      chk("idle_underflow", underflow, (p % 32) == 3);
    end

    // Impulse of 64 followed by zeros.
    do_reset();
    xs[0] = 64;
    xm = xs;
    stream(120);

    // DC step of 1000.
    do_reset();
    for (int m = 0; m < 32; m++) xs[m] = 1000;
    xm = xs;
    stream(200);
    chk("dc_final", dout, 1000);

    // Full-scale positive, full-scale negative, then alternating extremes.
    do_reset();
    for (int m = 0; m < 6; m++)  xs[m] = MAXV;
    for (int m = 6; m < 12; m++) xs[m] = MINV;
    for (int m = 12; m < 20; m++) xs[m] = (m % 2 == 0) ? MAXV : MINV;
    xm = xs;
    stream(420);
    chk("sat_alt_lo", dout >= MINV, 1'b1);
    chk("sat_alt_hi", dout <= MAXV, 1'b1);
    stream(252);

    // First in_valid lands exactly on an empty consumption tick.
    do_reset();
    xm[1] = 64;
    clk1(1'b0, '0);
    clk1(1'b0, '0);
    clk1(1'b0, '0);
    chk("sim_underflow", underflow, 1'b1);
    chk("sim_in_ready", in_ready, 1'b1);
    clk1(1'b1, DW'(64));
    chk("sim_in_ready_after", in_ready, 1'b0);
    for (int c = 0; c < 146; c++) begin
      clk1(1'b0, '0);
      chk("sim_in_ready_run", in_ready, p >= 36);
      chk("sim_underflow_run", underflow, ((p % 32) == 3) && (p != 35));
    end

    // Asynchronous reset with a full buffer, then impulse with an en=0 pause.
    do_reset();
    for (int m = 0; m < 32; m++) xs[m] = 1000;
    xm = xs;
    stream(101);
    chk("pre_rst_dout", dout, 1000);
    chk("pre_rst_full", in_ready, 1'b0);
    do_reset();
    xs[0] = 64;
    xm = xs;
    for (int c = 0; c < 160; c++) begin
      logic go;
      en = (c < 40) || (c >= 60);
      go = in_ready;
      clk1(1'b1, DW'(xs[idx]));
      if (go) idx++;
      chk("pause_underflow", underflow, 1'b0);
    end
    en = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
